// File: rtl/otl_dma_ring_writer.sv
// otl_dma_ring_writer
// Pops packed sample words from the ADC sample FIFO and writes each one as a
// single-word memory write into a circular buffer [base, base + len words).
// It reports the next write index, a wrap pulse and a half-buffer interrupt
// pulse so software can drain one half while capture fills the other.
//
// Optional build feature: define OTL_DMA_WORDCNT_EN to add a free-running
// 32-bit count of accepted writes (word_count) for detecting lapped rings.
//
// Ports:
//   clk          system clock (sys_clk), rising edge
//   reset        asynchronous active-low reset, released synchronously
//   enable       capture enable; its rising edge latches base/length
//   base_addr    ring base byte address (DATAW/8 aligned)
//   ring_words   ring length in words (0 is treated as 1)
//   fifo_rddata  FIFO read data, valid the cycle after fifo_rden
//   fifo_empty   FIFO empty flag
//   fifo_full    FIFO almost-full flag (feeds the sticky overflow flag)
//   fifo_rden    FIFO pop strobe
//   wraddr       memory write byte address
//   wrdata       memory write data
//   wrvalid      write request valid
//   wrready      write accepted
//   wr_ptr       index of the next word to be written
//   wrap         one-cycle pulse after the write that wraps the pointer
//   irq_half     one-cycle pulse after the half-buffer write and each wrap
//   overflow     sticky: fifo_full seen while enabled
//   word_count   accepted-write count (OTL_DMA_WORDCNT_EN only)
//   dbg_state    current FSM state (IDLE=0, POP=1, LOAD=2, WRITE=3)
//
// Handshake: a write transfers on any rising edge where wrvalid and wrready
// are both high. Once wrvalid is raised, it and wraddr/wrdata hold steady
// until that transfer; wrvalid never drops before acceptance.
module otl_dma_ring_writer #(
  parameter int ADDRW = 32,
  parameter int DATAW = 32,
  parameter int PTRW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [PTRW-1:0]  ring_words,
  input  logic [DATAW-1:0] fifo_rddata,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  output logic             fifo_rden,
  output logic [ADDRW-1:0] wraddr,
  output logic [DATAW-1:0] wrdata,
  output logic             wrvalid,
  input  logic             wrready,
  output logic [PTRW-1:0]  wr_ptr,
  output logic             wrap,
  output logic             irq_half,
  output logic             overflow,
`ifdef OTL_DMA_WORDCNT_EN
  output logic [31:0]      word_count,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    LOAD  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic             en_q;
  logic             en_rise;
  logic [ADDRW-1:0] base_q;
  logic [PTRW-1:0]  len_q;
  logic             accept;
  logic             last_word;
  logic             half_word;
  logic [ADDRW-1:0] ptr_off;

  assign en_rise = enable & ~en_q;
  assign accept  = (state == WRITE) & wrready;

  // len_q >= 1 always, so len_q-1 is a valid index. With len_q == 1 the
  // half index underflows to all-ones, which wr_ptr never reaches; the
  // wrap term supplies the interrupt in that case.
  assign last_word = (wr_ptr == len_q - PTRW'(1));
  assign half_word = (wr_ptr == (len_q >> 1) - PTRW'(1));
  assign ptr_off   = ADDRW'(wr_ptr) * ADDRW'(DATAW / 8);

  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and strobes
  always_comb begin
    state_nxt = state;
    fifo_rden = 1'b0;
    wrvalid   = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) state_nxt = POP;
      end
      POP: begin
        fifo_rden = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        wrvalid = 1'b1;
        // A popped word always completes; enable only gates the next pop.
        if (wrready) state_nxt = (enable && !fifo_empty) ? POP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch, datapath, pointer, pulses and sticky flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q     <= 1'b0;
      base_q   <= '0;
      len_q    <= PTRW'(1);
      wraddr   <= '0;
      wrdata   <= '0;
      wr_ptr   <= '0;
      wrap     <= 1'b0;
      irq_half <= 1'b0;
      overflow <= 1'b0;
    end else begin
      en_q     <= enable;
      wrap     <= 1'b0;
      irq_half <= 1'b0;

      if (en_rise) begin
        base_q <= base_addr;
        len_q  <= (ring_words == '0) ? PTRW'(1) : ring_words;
      end

      if (state == LOAD) begin
        wrdata <= fifo_rddata;
        wraddr <= base_q + ptr_off;
      end

      if (accept) begin
        wrap     <= last_word;
        irq_half <= last_word | half_word;
      end

      if (en_rise)     wr_ptr <= '0;
      else if (accept) wr_ptr <= last_word ? '0 : wr_ptr + PTRW'(1);

      // A full FIFO on the enabling edge itself counts for the new session.
      if (en_rise)                 overflow <= fifo_full;
      else if (enable && fifo_full) overflow <= 1'b1;
    end
  end

`ifdef OTL_DMA_WORDCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      word_count <= '0;
    else if (en_rise) word_count <= '0;
    else if (accept)  word_count <= word_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_otl_dma_ring_writer.sv
`timescale 1ns/1ps
module tb_otl_dma_ring_writer;
  localparam int ADDRW = 32;
  localparam int DATAW = 32;
  localparam int PTRW  = 16;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             enable;
  logic [ADDRW-1:0] base_addr;
  logic [PTRW-1:0]  ring_words;
  logic [DATAW-1:0] fifo_rddata = '0;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_rden;
  logic [ADDRW-1:0] wraddr;
  logic [DATAW-1:0] wrdata;
  logic             wrvalid;
  logic             wrready;
  logic [PTRW-1:0]  wr_ptr;
  logic             wrap;
  logic             irq_half;
  logic             overflow;
  logic [1:0]       dbg_state;
`ifdef OTL_DMA_WORDCNT_EN
  logic [31:0]      word_count;
`endif

  otl_dma_ring_writer #(.ADDRW(ADDRW), .DATAW(DATAW), .PTRW(PTRW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .base_addr(base_addr), .ring_words(ring_words),
    .fifo_rddata(fifo_rddata), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_rden(fifo_rden), .wraddr(wraddr), .wrdata(wrdata),
    .wrvalid(wrvalid), .wrready(wrready), .wr_ptr(wr_ptr),
    .wrap(wrap), .irq_half(irq_half), .overflow(overflow),
`ifdef OTL_DMA_WORDCNT_EN
    .word_count(word_count),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- FIFO model (data valid the cycle after rden) ----------------
  logic [DATAW-1:0] fifo_mem [0:255];
  int unsigned fifo_wr_cnt = 0;
  int unsigned fifo_rd_cnt = 0;
  assign fifo_empty = (fifo_wr_cnt == fifo_rd_cnt);

  always @(posedge clk) begin
    if (fifo_rden) begin
      fifo_rddata <= fifo_mem[fifo_rd_cnt % 256];
      fifo_rd_cnt <= fifo_rd_cnt + 1;
    end
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_word(input logic [DATAW-1:0] w);
    fifo_mem[fifo_wr_cnt % 256] = w;
    fifo_wr_cnt++;
  endtask

  task automatic flush_fifo();
    fifo_wr_cnt = fifo_rd_cnt;
  endtask

  // ---------------- driver + reference model for one ring session ----------------
  // Reference: write k goes to base + (k mod len)*bytes, carrying the k-th
  // pushed word; wrap after k mod len == len-1; irq_half after that or after
  // k mod len == len/2-1; final pointer n mod len.
  task automatic run_scenario(input logic [ADDRW-1:0] base, input logic [PTRW-1:0] rw,
                              input int n, input int hold, input int pct, input bit seq_data,
                              output int nwrap, output int nirq);
    logic [DATAW-1:0] exp_q[$];
    logic [ADDRW-1:0] exp_addr_q[$];
    logic [ADDRW-1:0] prev_addr;
    logic [DATAW-1:0] prev_data;
    logic [DATAW-1:0] w;
    int  len, nacc, cyc, held, pend_idx;
    bit  pend, hold_prev, done;
    len = (rw == '0) ? 1 : int'(rw);
    enable  = 1'b0;
    wrready = 1'b0;
    repeat (2) @(negedge clk);
    base_addr  = base;
    ring_words = rw;
    for (int k = 0; k < n; k++) begin
      w = seq_data ? DATAW'(32'hA0 + k) : DATAW'($urandom);
      push_word(w);
      exp_q.push_back(w);
      exp_addr_q.push_back(base + ADDRW'((k % len) * (DATAW / 8)));
    end
    enable = 1'b1;
    @(negedge clk);
    // Config is latched now; later changes must be ignored.
    base_addr  = ~base;
    ring_words = rw + PTRW'(3);
    nacc = 0; cyc = 0; held = 0; pend_idx = 0;
    pend = 0; hold_prev = 0; done = 0; nwrap = 0; nirq = 0;
    prev_addr = '0; prev_data = '0;
    while (cyc < 40 * n + 60) begin
      check("wrap_pulse", wrap, pend && (pend_idx == len - 1));
      check("irq_half_pulse", irq_half,
            pend && (pend_idx == len - 1 || pend_idx == len / 2 - 1));
      nwrap += int'(wrap);
      nirq  += int'(irq_half);
      pend = 0;
      if (nacc == n && dbg_state == S_IDLE) begin
        done = 1;
        break;
      end
      if (hold_prev) begin
        check("hold_wrvalid", wrvalid, 1);
        check("hold_wraddr", wraddr, prev_addr);
        check("hold_wrdata", wrdata, prev_data);
        check("hold_no_rden", fifo_rden, 0);
      end
      hold_prev = 0;
      if (wrvalid && nacc == 0 && held < hold) begin
        wrready = 1'b0;
        held++;
      end else if (wrvalid) begin
        wrready = ($urandom_range(1, 100) <= pct);
      end else begin
        wrready = 1'($urandom_range(0, 1));
      end
      if (wrvalid && wrready) begin
        if (exp_addr_q.size() == 0) begin
          check("extra_write", 1, 0);
        end else begin
          check("wraddr", wraddr, exp_addr_q.pop_front());
          check("wrdata", wrdata, exp_q.pop_front());
        end
        pend_idx = nacc % len;
        pend = 1;
        nacc++;
      end else if (wrvalid) begin
        hold_prev = 1;
        prev_addr = wraddr;
        prev_data = wrdata;
      end
      @(negedge clk);
      cyc++;
    end
    check("session_complete", done, 1);
    check("final_wr_ptr", wr_ptr, PTRW'(n % len));
    check("no_overflow", overflow, 0);
`ifdef OTL_DMA_WORDCNT_EN
    check("word_count", word_count, n);
`endif
    enable  = 1'b0;
    wrready = 1'b0;
    flush_fifo();
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [ADDRW-1:0] base;
    logic [PTRW-1:0]  rw;
    int               n;
    int               hold;
    int               pct;
    bit               seq_data;
    logic [PTRW-1:0]  exp_ptr;
    int               exp_nwrap;
    int               exp_nirq;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int nw, ni, waited, nwrites, nrden;
    logic [DATAW-1:0] w0;
    vecs[0] = '{32'h0000_1000, 16'd4, 6, 0, 100, 1'b1, 16'd2, 1, 3};
    vecs[1] = '{32'h0000_2000, 16'd0, 3, 0, 100, 1'b0, 16'd0, 3, 3};
    vecs[2] = '{32'h0000_0000, 16'd5, 7, 5, 100, 1'b0, 16'd2, 1, 3};
    vecs[3] = '{32'hFFFF_FFF8, 16'd3, 4, 0,  60, 1'b0, 16'd1, 1, 3};
    vecs[4] = '{32'h0000_0040, 16'd2, 5, 2,  50, 1'b0, 16'd1, 2, 5};

    reset = 1'b0; enable = 1'b0; base_addr = '0; ring_words = '0;
    fifo_full = 1'b0; wrready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_fifo_rden", fifo_rden, 0);
    check("rst_wrvalid", wrvalid, 0);
    check("rst_wraddr", wraddr, 0);
    check("rst_wrdata", wrdata, 0);
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_wrap", wrap, 0);
    check("rst_irq_half", irq_half, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", dbg_state, S_IDLE);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted mid-WRITE with wrvalid high
    base_addr = 32'h0000_6000; ring_words = 16'd4;
    push_word(32'hDEAD_BEEF);
    enable = 1'b1;
    fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    waited = 0;
    while (!wrvalid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("pre_rst_wrvalid", wrvalid, 1);
    check("pre_rst_overflow", overflow, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_wrvalid", wrvalid, 0);
    check("arst_wraddr", wraddr, 0);
    check("arst_wrdata", wrdata, 0);
    check("arst_overflow", overflow, 0);
    check("arst_fifo_rden", fifo_rden, 0);
    check("arst_state", dbg_state, S_IDLE);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_state", dbg_state, S_IDLE);
    check("post_rst_wr_ptr", wr_ptr, 0);
    flush_fifo();

    // Table-driven sessions
    for (int i = 0; i < 5; i++) begin
      run_scenario(vecs[i].base, vecs[i].rw, vecs[i].n, vecs[i].hold, vecs[i].pct,
                   vecs[i].seq_data, nw, ni);
      check($sformatf("vec%0d_wr_ptr", i), wr_ptr, vecs[i].exp_ptr);
      check($sformatf("vec%0d_nwrap", i), nw, vecs[i].exp_nwrap);
      check($sformatf("vec%0d_nirq", i), ni, vecs[i].exp_nirq);
    end

    // Randomized sessions checked against the reference model
    for (int i = 0; i < 12; i++) begin
      run_scenario(ADDRW'($urandom) & ~ADDRW'(3), PTRW'($urandom_range(0, 9)),
                   $urandom_range(1, 20), $urandom_range(0, 3),
                   $urandom_range(30, 100), 1'b0, nw, ni);
    end

    // enable dropped in the LOAD cycle
    repeat (2) @(negedge clk);
    base_addr = 32'h0000_3000; ring_words = 16'd8;
    w0 = 32'h1234_5678;
    push_word(w0); push_word(32'h1111_1111); push_word(32'h2222_2222);
    enable = 1'b1; wrready = 1'b1;
    waited = 0;
    while (dbg_state != S_LOAD && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("reached_load", dbg_state, S_LOAD);
    enable = 1'b0;
    nwrites = 0; nrden = 0;
    for (int c = 0; c < 15; c++) begin
      nrden += int'(fifo_rden);
      if (wrvalid && wrready) begin
        if (nwrites == 0) begin
          check("drop_wraddr", wraddr, 32'h0000_3000);
          check("drop_wrdata", wrdata, w0);
        end
        nwrites++;
      end
      @(negedge clk);
    end
    check("drop_nwrites", nwrites, 1);
    check("drop_no_rden", nrden, 0);
    check("drop_state", dbg_state, S_IDLE);
    check("drop_wr_ptr", wr_ptr, 1);
    check("drop_fifo_nonempty", fifo_empty, 0);
    flush_fifo();
    wrready = 1'b0;

    // Sticky overflow, cleared by the next enable rising edge
    repeat (2) @(negedge clk);
    base_addr = 32'h0000_5000; ring_words = 16'd4;
    push_word(32'hCAFE_0001);
    enable = 1'b1; wrready = 1'b1;
    waited = 0;
    while (!(wr_ptr == 16'd1 && dbg_state == S_IDLE) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ovf_pre_wr_ptr", wr_ptr, 1);
    check("ovf_pre", overflow, 0);
    fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    check("ovf_set", overflow, 1);
    repeat (3) @(negedge clk);
    check("ovf_sticky", overflow, 1);
    enable = 1'b0;
    @(negedge clk);
    check("ovf_sticky_disabled", overflow, 1);
    check("ovf_wr_ptr_kept", wr_ptr, 1);
    enable = 1'b1;
    @(negedge clk);
    check("ovf_cleared", overflow, 0);
    check("ovf_wr_ptr_cleared", wr_ptr, 0);
    enable = 1'b0; wrready = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/otl_dma_ring_writer.md
Name: otl_dma_ring_writer

Overview:
- Downstream consumer of the ADC sample FIFO, in the sys_clk domain. Pops packed sample words from the FIFO read port and issues single-word writes on a valid/ready memory write interface.
- Writes go into a circular buffer defined by a base address and a length in words.
- Reports the current write pointer, wrap events and a half-buffer interrupt pulse so software can drain the buffer while capture continues.

Parameters:
- ADDRW, 32, width of memory byte addresses.
- DATAW, 32, width of FIFO words and memory write data; must be a multiple of 8.
- PTRW, 16, width of the word pointer; ring length is at most 2^PTRW words.

Ports:
- clk  in  1  system clock (sys_clk); all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting it low clears all state immediately; release is synchronous to clk.
- enable  in  1  capture enable from the config register block.
- base_addr  in  ADDRW  ring base byte address; must be DATAW/8 aligned.
- ring_words  in  PTRW  ring length in words; 0 is treated as 1.
- fifo_rddata  in  DATAW  FIFO read data; valid 1 cycle after fifo_rden.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO almost-full flag.
- fifo_rden  out  1  FIFO pop strobe.
- wraddr  out  ADDRW  memory write byte address.
- wrdata  out  DATAW  memory write data.
- wrvalid  out  1  write request valid.
- wrready  in  1  write accepted.
- wr_ptr  out  PTRW  index of the next word to be written.
- wrap  out  1  one-cycle pulse when the pointer wraps to 0.
- irq_half  out  1  one-cycle pulse on completing the write of word index ring_words/2 - 1 (integer divide), and on each wrap.
- overflow  out  1  sticky flag: fifo_full was seen high while enabled.

Behaviour:
- Reset values: fifo_rden=0, wrvalid=0, wraddr=0, wrdata=0, wr_ptr=0, wrap=0, irq_half=0, overflow=0, state=IDLE.
- Config latching: on the rising edge of enable (registered enable 0->1), latch base_addr and ring_words (0 becomes 1), clear wr_ptr to 0 and clear overflow. Changes to base_addr or ring_words while enabled have no effect.
- FSM states: IDLE, POP, LOAD, WRITE.
  - IDLE: leave when enable=1 and fifo_empty=0, going to POP.
  - POP: fifo_rden=1 for exactly this cycle, then go to LOAD. POP is entered only with fifo_empty=0, so no underflow is possible.
  - LOAD: capture fifo_rddata into wrdata; set wraddr = base + wr_ptr*(DATAW/8), truncated to ADDRW; go to WRITE.
  - WRITE: wrvalid=1. wraddr and wrdata stay stable until wrready=1. On the accept cycle:
    - wr_ptr advances; if wr_ptr == ring_words-1 it becomes 0 and wrap pulses the next cycle.
    - Next state is POP if enable=1 and fifo_empty=0; otherwise IDLE.
- Latency and throughput: fifo_empty low in IDLE leads to the first wrvalid 3 cycles later. Sustained rate is 1 word per 3 cycles with wrready tied high.
- enable dropped mid-transaction: a word already popped (in LOAD or WRITE) is always written. The FSM then returns to IDLE and no further pops occur.
- wrvalid never deasserts without wrready; no data is dropped once popped.
- overflow: set when enable=1 and fifo_full=1; it stays set until the next enable rising edge. It does not affect the data path.
- Interrupts: irq_half and wrap fire in the cycle after the accepting edge. With ring_words=1, every write produces both wrap and irq_half.

Optional Feature:
- Macro OTL_DMA_WORDCNT_EN.
- Defined: adds output word_count, 32 bits, which counts every accepted write and wraps modulo 2^32. It is cleared by reset and on the enable rising edge, and lets software detect lapped rings.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset low mid-WRITE with wrvalid=1 -> all outputs 0 asynchronously; after release, state is IDLE and wr_ptr=0.
- base=0x1000, ring_words=4, 6 words (0xA0..0xA5) in the FIFO, wrready=1 -> writes in this order:
  - 0x1000=A0, 0x1004=A1, 0x1008=A2, 0x100C=A3, 0x1000=A4, 0x1004=A5;
  - irq_half after A1; wrap and irq_half after A3; final wr_ptr=2.
- wrready held low 5 cycles during WRITE -> wraddr and wrdata stable, wrvalid=1 throughout, fifo_rden=0 throughout; exactly one write on release.
- enable dropped in the LOAD cycle -> that word is still written, then IDLE with no further fifo_rden while the FIFO is non-empty.
- fifo_full pulsed 1 cycle while enabled -> overflow=1 and stays 1; an enable 0->1 toggle clears it and wr_ptr returns to 0.
- ring_words=0 with 3 words -> all 3 written to base; wrap and irq_half pulse after each write (and, with OTL_DMA_WORDCNT_EN, word_count=3).
